// File: rtl/uart_csr_bridge.sv
// UART byte-stream to CSR bus bridge: parses 'W'/'R' command packets, issues single-cycle
// CSR strobes and returns ACK (plus read data) or NAK to the UART transmitter.
//
// state  | meaning
// IDLE   | waiting for a 'W' or 'R' command byte
// ADDR   | expecting the address byte
// DATA   | collecting write data d0..d3, LSB first
// CRC    | expecting the trailing CRC byte
// EXEC   | issuing the CSR strobe, or diverting to NAK
// RDWAIT | capturing registered read data
// RESP   | sending ACK and read data bytes
// NAK    | sending the NAK byte
module uart_csr_bridge #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        csr_wr_en,
   output logic        csr_rd_en,
   output logic [7:0]  csr_addr,
   output logic [31:0] csr_wdata,
   input  logic [31:0] csr_rdata,
   input  logic        crc_en,
   output logic        busy,
   output logic [7:0]  err_cnt
);
   localparam logic [7:0] CMD_WR   = 8'h57;
   localparam logic [7:0] CMD_RD   = 8'h52;
   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_CRC, S_EXEC, S_RDWAIT, S_RESP, S_NAK
   } state_t;

   state_t        state_q, state_d;
   logic          is_write_q, crc_en_q, crc_bad_q;
   logic [7:0]    crc_q, addr_q, err_cnt_q;
   logic [31:0]   wdata_q, rdata_q;
   logic [1:0]    data_idx_q;
   logic [2:0]    resp_idx_q;
   logic [TW-1:0] to_cnt_q;
   logic          is_cmd, in_rx_phase, timeout, exec_ok, tx_hs, resp_last, err_evt;

   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
      logic [7:0] c;
      c = crc ^ b;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   assign is_cmd      = (rx_data == CMD_WR) || (rx_data == CMD_RD);
   assign in_rx_phase = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CRC);
   assign timeout     = in_rx_phase && !rx_valid && (to_cnt_q == '0);
   assign exec_ok     = (addr_q[1:0] == 2'b00) && !crc_bad_q;
   assign tx_hs       = tx_valid && tx_ready;
   assign resp_last   = is_write_q || (resp_idx_q == 3'd4);

   // Coincident error events collapse into a single increment.
   assign err_evt = ((state_q == S_IDLE) && rx_valid && !is_cmd)
                  || timeout
                  || (rx_valid && ((state_q == S_EXEC) || (state_q == S_RDWAIT) ||
                                   (state_q == S_RESP) || (state_q == S_NAK)))
                  || ((state_q == S_EXEC) && !exec_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (rx_valid && is_cmd) state_d = S_ADDR;
         S_ADDR:   if (rx_valid)  state_d = is_write_q ? S_DATA : (crc_en_q ? S_CRC : S_EXEC);
                   else if (timeout) state_d = S_IDLE;
         S_DATA:   if (rx_valid) begin
                      if (data_idx_q == 2'd3) state_d = crc_en_q ? S_CRC : S_EXEC;
                   end else if (timeout) state_d = S_IDLE;
         S_CRC:    if (rx_valid) state_d = S_EXEC;
                   else if (timeout) state_d = S_IDLE;
         // CRC failures also pass through EXEC so NAK timing matches the aligned case.
         S_EXEC:   state_d = exec_ok ? (is_write_q ? S_RESP : S_RDWAIT) : S_NAK;
         S_RDWAIT: state_d = S_RESP;
         S_RESP:   if (tx_hs && resp_last) state_d = S_IDLE;
         S_NAK:    if (tx_hs) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      csr_wr_en = 1'b0;
      csr_rd_en = 1'b0;
      case (state_q)
         S_EXEC: begin
            csr_wr_en = exec_ok && is_write_q;
            csr_rd_en = exec_ok && !is_write_q;
         end
         S_RESP: begin
            tx_valid = 1'b1;
            case (resp_idx_q)
               3'd0:    tx_data = ACK_BYTE;
               3'd1:    tx_data = rdata_q[7:0];
               3'd2:    tx_data = rdata_q[15:8];
               3'd3:    tx_data = rdata_q[23:16];
               default: tx_data = rdata_q[31:24];
            endcase
         end
         S_NAK: begin
            tx_valid = 1'b1;
            tx_data  = NAK_BYTE;
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign csr_addr  = addr_q;
   assign csr_wdata = wdata_q;
   assign err_cnt   = err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_write_q <= 1'b0;
         crc_en_q   <= 1'b0;
         crc_bad_q  <= 1'b0;
         crc_q      <= 8'h00;
         addr_q     <= 8'h00;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         data_idx_q <= 2'd0;
         resp_idx_q <= 3'd0;
         to_cnt_q   <= '0;
         err_cnt_q  <= 8'h00;
      end else begin
         if (in_rx_phase) begin
            if (rx_valid)             to_cnt_q <= TO_LOAD;
            else if (to_cnt_q != '0)  to_cnt_q <= to_cnt_q - 1'b1;
         end
         case (state_q)
            S_IDLE: if (rx_valid && is_cmd) begin
               is_write_q <= (rx_data == CMD_WR);
               crc_en_q   <= crc_en;
               crc_bad_q  <= 1'b0;
               crc_q      <= crc8_upd(8'h00, rx_data);
               data_idx_q <= 2'd0;
               to_cnt_q   <= TO_LOAD;
            end
            S_ADDR: if (rx_valid) begin
               addr_q <= rx_data;
               crc_q  <= crc8_upd(crc_q, rx_data);
            end
            S_DATA: if (rx_valid) begin
               wdata_q[{data_idx_q, 3'b000} +: 8] <= rx_data;
               data_idx_q <= data_idx_q + 2'd1;
               crc_q      <= crc8_upd(crc_q, rx_data);
            end
            S_CRC:    if (rx_valid) crc_bad_q <= (rx_data != crc_q);
            S_EXEC:   resp_idx_q <= 3'd0;
            S_RDWAIT: rdata_q <= csr_rdata;
            S_RESP:   if (tx_hs && !resp_last) resp_idx_q <= resp_idx_q + 3'd1;
            default: ;
         endcase
         if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end
endmodule

// File: tb/tb_uart_csr_bridge.sv
// Bench for uart_csr_bridge: table of packets with expected tx bytes/strobes fed through
// scoreboard queues, plus hand-written timing, stall, timeout, reset and saturation sequences.
module tb_uart_csr_bridge;
   logic        clk = 1'b0;
   logic        rst_n, rx_valid, tx_valid, tx_ready, csr_wr_en, csr_rd_en, crc_en, busy;
   logic [7:0]  rx_data, tx_data, csr_addr, err_cnt;
   logic [31:0] csr_wdata, csr_rdata;
   logic        rdy_force, rdy_rand, rnd_q;

   always #5 clk = ~clk;

   uart_csr_bridge #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .crc_en(crc_en),
      .busy(busy), .err_cnt(err_cnt)
   );

   assign tx_ready = rdy_rand ? rnd_q : rdy_force;
   always @(posedge clk) rnd_q <= ($urandom_range(0, 3) != 0);

   // CSR register model
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (csr_wr_en) mem[csr_addr[7:2]] <= csr_wdata;
      if (csr_rd_en) csr_rdata <= mem[csr_addr[7:2]];
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed { logic wr; logic [7:0] a; logic [31:0] d; } stb_t;
   logic [7:0] tx_q [$];
   stb_t       stb_q [$];

   // tx scoreboard and hold-while-stalled check
   logic       stall_prev = 1'b0;
   logic [7:0] held = 8'h00;
   logic [7:0] tx_exp;
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev) check("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, held}));
         if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_unexpected: got byte %0h, expected none", tx_data);
            end else begin
               tx_exp = tx_q.pop_front();
               check("tx_byte", 32'(tx_data), 32'(tx_exp));
            end
         end
         stall_prev <= tx_valid && !tx_ready;
         held       <= tx_data;
      end else begin
         stall_prev <= 1'b0;
      end
   end

   stb_t s_mon;
   always @(negedge clk) begin
      if (rst_n && (csr_wr_en || csr_rd_en)) begin
         if (stb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stb_unexpected: got wr=%0b rd=%0b addr=%0h, expected none",
                     csr_wr_en, csr_rd_en, csr_addr);
         end else begin
            s_mon = stb_q.pop_front();
            check("stb_kind", 32'({csr_wr_en, csr_rd_en}), 32'({s_mon.wr, !s_mon.wr}));
            check("stb_addr", 32'(csr_addr), 32'(s_mon.a));
            if (s_mon.wr) check("stb_wdata", csr_wdata, s_mon.d);
         end
      end
   end

   typedef struct {
      int          n;
      logic [47:0] pk;
      logic        ce;
      logic        bad;
      int          ntx;
      logic [39:0] tx;
      int          stb;
      logic [7:0]  a;
      logic [31:0] d;
      int          einc;
   } vec_t;

   function automatic vec_t mk(int n, logic [47:0] pk, logic ce, logic bad, int ntx,
                               logic [39:0] tx, int stb, logic [7:0] a, logic [31:0] d, int einc);
      vec_t v;
      v.n = n; v.pk = pk; v.ce = ce; v.bad = bad; v.ntx = ntx; v.tx = tx;
      v.stb = stb; v.a = a; v.d = d; v.einc = einc;
      return v;
   endfunction

   // LFSR-form CRC-8, poly 0x07, MSB first
   function automatic logic [7:0] crc_step(logic [7:0] c, logic [7:0] b);
      logic [7:0] r;
      logic       fb;
      r = c;
      for (int k = 7; k >= 0; k--) begin
         fb = r[7] ^ b[k];
         r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic push_stb(input logic wr, input logic [7:0] a, input logic [31:0] d);
      stb_t s;
      s.wr = wr; s.a = a; s.d = d;
      stb_q.push_back(s);
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while ((busy || tx_q.size() != 0 || stb_q.size() != 0) && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k >= 300) begin
         errors++;
         $display("FAIL %s: no completion within 300 cycles (busy=%0b tx_pending=%0d stb_pending=%0d), required idle",
                  name, busy, tx_q.size(), stb_q.size());
         tx_q.delete();
         stb_q.delete();
      end
   endtask

   vec_t       vecs [12];
   vec_t       v;
   logic [7:0] b, crc;
   int         exp_err;
   int         k;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //              n  packet bytes          ce  bad ntx tx bytes            stb addr   wdata         einc
      vecs[0]  = mk(6, 48'h572C0000AA42, 1'b0, 1'b0, 1, 40'h0600000000, 1, 8'h2C, 32'h42AA0000, 0);
      vecs[1]  = mk(2, 48'h522C00000000, 1'b0, 1'b0, 5, 40'h060000AA42, 2, 8'h2C, 32'h0,        0);
      vecs[2]  = mk(6, 48'h57080B000000, 1'b1, 1'b1, 1, 40'h1500000000, 0, 8'h00, 32'h0,        1);
      vecs[3]  = mk(6, 48'h57080B000000, 1'b1, 1'b0, 1, 40'h0600000000, 1, 8'h08, 32'h0000000B, 0);
      vecs[4]  = mk(2, 48'h520800000000, 1'b1, 1'b0, 5, 40'h060B000000, 2, 8'h08, 32'h0,        0);
      vecs[5]  = mk(2, 48'h520500000000, 1'b0, 1'b0, 1, 40'h1500000000, 0, 8'h00, 32'h0,        1);
      vecs[6]  = mk(6, 48'h570611223344, 1'b1, 1'b0, 1, 40'h1500000000, 0, 8'h00, 32'h0,        1);
      vecs[7]  = mk(1, 48'h410000000000, 1'b0, 1'b0, 0, 40'h0,          0, 8'h00, 32'h0,        1);
      vecs[8]  = mk(6, 48'h57FC78563412, 1'b0, 1'b0, 1, 40'h0600000000, 1, 8'hFC, 32'h12345678, 0);
      vecs[9]  = mk(2, 48'h52FC00000000, 1'b0, 1'b0, 5, 40'h0678563412, 2, 8'hFC, 32'h0,        0);
      vecs[10] = mk(6, 48'h5710A55AC33C, 1'b0, 1'b0, 1, 40'h0600000000, 1, 8'h10, 32'h3CC35AA5, 0);
      vecs[11] = mk(2, 48'h520500000000, 1'b1, 1'b1, 1, 40'h1500000000, 0, 8'h00, 32'h0,        1);

      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; crc_en = 1'b0;
      rdy_force = 1'b1; rdy_rand = 1'b0; exp_err = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_wr_en", 32'(csr_wr_en), 32'd0);
      check("rst_rd_en", 32'(csr_rd_en), 32'd0);
      check("rst_addr", 32'(csr_addr), 32'd0);
      check("rst_wdata", csr_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Write latency: strobe at T+1, ACK from T+2
      rdy_force = 1'b0;
      push_stb(1'b1, 8'h04, 32'h00000007);
      tx_q.push_back(8'h06);
      send_byte(8'h57); send_byte(8'h04); send_byte(8'h07);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("wr_t1_strobe", 32'(csr_wr_en), 32'd1);
      check("wr_t1_addr", 32'(csr_addr), 32'h04);
      check("wr_t1_wdata", csr_wdata, 32'h7);
      check("wr_t1_no_tx", 32'(tx_valid), 32'd0);
      check("wr_t1_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("wr_t2_tx", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h06}));
      check("wr_t2_strobe_off", 32'(csr_wr_en), 32'd0);
      rdy_force = 1'b1;
      wait_done("wr_timing_done");
      check("wr_err_cnt", 32'(err_cnt), 32'd0);

      rdy_rand = 1'b1;
      for (int i = 0; i < 12; i++) begin
         v = vecs[i];
         for (int j = 0; j < v.ntx; j++) tx_q.push_back(v.tx[39-8*j -: 8]);
         if (v.stb != 0) push_stb(v.stb == 1, v.a, v.d);
         crc_en = v.ce;
         crc = 8'h00;
         for (int j = 0; j < v.n; j++) begin
            b = v.pk[47-8*j -: 8];
            crc = crc_step(crc, b);
            send_byte(b);
            crc_en = !v.ce;
         end
         if (v.ce) send_byte(crc ^ {7'd0, v.bad});
         crc_en = 1'b0;
         wait_done("vec_done");
         exp_err += v.einc;
         check("vec_err_cnt", 32'(err_cnt), 32'(exp_err));
      end
      rdy_rand = 1'b0;
      rdy_force = 1'b1;

      // Read latency and a 3-cycle stall on the second response byte
      rdy_force = 1'b0;
      push_stb(1'b0, 8'h2C, 32'h0);
      tx_q.push_back(8'h06); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
      tx_q.push_back(8'hAA); tx_q.push_back(8'h42);
      send_byte(8'h52); send_byte(8'h2C);
      check("rd_t1_strobe", 32'(csr_rd_en), 32'd1);
      check("rd_t1_addr", 32'(csr_addr), 32'h2C);
      @(posedge clk); #1;
      check("rd_t2_no_tx", 32'(tx_valid), 32'd0);
      @(posedge clk); #1;
      check("rd_t3_tx", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h06}));
      rdy_force = 1'b1;
      @(posedge clk); #1;
      rdy_force = 1'b0;
      for (int j = 0; j < 3; j++) begin
         check("rd_stall_byte", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h00}));
         @(posedge clk); #1;
      end
      rdy_force = 1'b1;
      wait_done("rd_stall_done");

      // Timeout after a partial write: busy holds for 16 idle cycles then drops
      send_byte(8'h57); send_byte(8'h10); send_byte(8'h01); send_byte(8'h02);
      repeat (15) begin @(posedge clk); #1; end
      check("to_busy_held", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("to_busy_fall", 32'(busy), 32'd0);
      exp_err++;
      check("to_err_cnt", 32'(err_cnt), 32'(exp_err));
      push_stb(1'b0, 8'h10, 32'h0);
      tx_q.push_back(8'h06); tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
      tx_q.push_back(8'hC3); tx_q.push_back(8'h3C);
      send_byte(8'h52); send_byte(8'h10);
      wait_done("to_read_done");
      check("to_read_err_cnt", 32'(err_cnt), 32'(exp_err));

      // Reset asserted while a response is pending
      rdy_force = 1'b0;
      push_stb(1'b0, 8'h2C, 32'h0);
      tx_q.push_back(8'h06);
      send_byte(8'h52); send_byte(8'h2C);
      k = 0;
      while (!tx_valid && k < 20) begin @(posedge clk); #1; k++; end
      check("rst_resp_reached", 32'(tx_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
      tx_q.delete();
      stb_q.delete();
      rdy_force = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      check("rst_after_busy", 32'(busy), 32'd0);

      // Junk bytes in IDLE saturate the error counter
      for (int j = 0; j < 300; j++) begin
         send_byte(8'hFF);
         if (j == 99) check("sat_err_100", 32'(err_cnt), 32'd100);
      end
      check("sat_err_255", 32'(err_cnt), 32'd255);
      check("sat_busy", 32'(busy), 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      check("sat_no_tx", 32'(tx_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
